// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: ID and ID/EX operand descriptors, the EX/MEM RAM handshake, and the
// per-stage stall/bubble/flush controls returned to the pipeline.
// The performance counter signals exist only when HAZARD_PERF_CNT_EN is defined.

`ifndef HAZARD_STALL_CTRL_DEFS
`define HAZARD_STALL_CTRL_DEFS
`define REG_OP_BUS        2:0
`define REG_ADDR_BUS      2:0
`define WB_DATA_OP_BUS    1:0
`define REG_OP_NOP        3'd0
`define REG_OP_REG        3'd1
`define REG_OP_IH         3'd2
`define REG_OP_SP         3'd3
`define REG_OP_T          3'd4
`define WB_DATA_OP_NONE   2'd0
`define WB_DATA_OP_ALU    2'd1
`define WB_DATA_OP_MEM    2'd2
`endif

interface hazard_stall_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
    #(parameter int unsigned CNT_W = 16)
`endif
    ;

    logic [`REG_OP_BUS]     id_reg1_op;
    logic [`REG_OP_BUS]     id_reg2_op;
    logic [`REG_ADDR_BUS]   id_reg1_addr;
    logic [`REG_ADDR_BUS]   id_reg2_addr;
    logic [`REG_OP_BUS]     ide_reg_op;
    logic [`REG_ADDR_BUS]   ide_wb_addr;
    logic [`WB_DATA_OP_BUS] ide_wb_data_op;
    logic                   id_branch_taken;
    logic                   exm_ram_req;
    logic                   ram_ready;

    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_bubble;
    logic exmem_stall;
    logic memwb_bubble;
    logic stall_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] mem_stall_cnt;
`endif

    // Pipeline side: supplies hazard information, consumes stall controls.
    modport master (
        output id_reg1_op, id_reg2_op, id_reg1_addr, id_reg2_addr,
        output ide_reg_op, ide_wb_addr, ide_wb_data_op,
        output id_branch_taken, exm_ram_req, ram_ready,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
        input  exmem_stall, memwb_bubble, stall_timeout
`ifdef HAZARD_PERF_CNT_EN
        , input lu_stall_cnt, mem_stall_cnt
`endif
    );

    // Controller side.
    modport slave (
        input  id_reg1_op, id_reg2_op, id_reg1_addr, id_reg2_addr,
        input  ide_reg_op, ide_wb_addr, ide_wb_data_op,
        input  id_branch_taken, exm_ram_req, ram_ready,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
        output exmem_stall, memwb_bubble, stall_timeout
`ifdef HAZARD_PERF_CNT_EN
        , output lu_stall_cnt, mem_stall_cnt
`endif
    );

endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble insertion, RAM-wait pipeline freeze with timeout abort,
// and branch flush qualification. All stall controls are combinational from state and inputs.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.

`ifndef HAZARD_STALL_CTRL_DEFS
`define HAZARD_STALL_CTRL_DEFS
`define REG_OP_BUS        2:0
`define REG_ADDR_BUS      2:0
`define WB_DATA_OP_BUS    1:0
`define REG_OP_NOP        3'd0
`define REG_OP_REG        3'd1
`define REG_OP_IH         3'd2
`define REG_OP_SP         3'd3
`define REG_OP_T          3'd4
`define WB_DATA_OP_NONE   2'd0
`define WB_DATA_OP_ALU    2'd1
`define WB_DATA_OP_MEM    2'd2
`endif

module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_ctrl_if.slave bus
);

    // Reject illegal configurations at elaboration time.
    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
        $error("hazard_stall_ctrl: MEM_TIMEOUT must be 2..255 and CNT_W >= 1");
    end

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       stall_timeout_q;

    logic op1_hit;
    logic op2_hit;
    logic lu;
    logic abort;
    logic mh;

    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_bubble;
    logic exmem_stall;
    logic memwb_bubble;

    // Hazard conditions: operand matches against the ID/EX destination, the RAM hold and abort.
    always_comb begin
        op1_hit = (bus.id_reg1_op == bus.ide_reg_op) && (bus.id_reg1_op != `REG_OP_NOP) &&
                  ((bus.id_reg1_op != `REG_OP_REG) || (bus.id_reg1_addr == bus.ide_wb_addr));
        op2_hit = (bus.id_reg2_op == bus.ide_reg_op) && (bus.id_reg2_op != `REG_OP_NOP) &&
                  ((bus.id_reg2_op != `REG_OP_REG) || (bus.id_reg2_addr == bus.ide_wb_addr));
        lu      = (bus.ide_wb_data_op == `WB_DATA_OP_MEM) && (op1_hit || op2_hit);
        // Abort only when the last permitted wait cycle still sees no ready.
        abort   = (state_q == StMemWait) && (wait_cnt_q == WaitLast) && !bus.ram_ready;
        mh      = bus.exm_ram_req && !bus.ram_ready && !abort;
    end

    // Next-state logic for the RAM wait FSM and its wait counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun: begin
                // Holding at zero in RUN makes entry into MEM_WAIT start from zero.
                wait_cnt_d = 8'd0;
                if (mh) begin
                    state_d = StMemWait;
                end
            end
            StMemWait: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (bus.ram_ready || abort) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Stall/bubble/flush decode with priority mh > lu > flush; the abort cycle releases everything.
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_stall  = 1'b0;
        memwb_bubble = 1'b0;
        if (abort) begin
            // The aborted access leaves EX/MEM; nothing is held this cycle.
        end else if (mh) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (lu) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            // A branch held in ID during a stall re-resolves and flushes once released.
            ifid_flush = bus.id_branch_taken;
        end
    end

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StRun;
            wait_cnt_q      <= 8'd0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (abort) begin
                stall_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.pc_stall      = pc_stall;
    assign bus.ifid_stall    = ifid_stall;
    assign bus.ifid_flush    = ifid_flush;
    assign bus.idex_stall    = idex_stall;
    assign bus.idex_bubble   = idex_bubble;
    assign bus.exmem_stall   = exmem_stall;
    assign bus.memwb_bubble  = memwb_bubble;
    assign bus.stall_timeout = stall_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q;
    logic [CNT_W-1:0] mem_cnt_q;

    // Saturating counts of bubble cycles and memory-hold cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            if (idex_bubble && !(&lu_cnt_q)) begin
                lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            end
            if (exmem_stall && !(&mem_cnt_q)) begin
                mem_cnt_q <= mem_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.lu_stall_cnt  = lu_cnt_q;
    assign bus.mem_stall_cnt = mem_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random stimulus, checked by a scoreboard
// fed from a cycle-level reference model of the hazard rules.

`ifndef HAZARD_STALL_CTRL_DEFS
`define HAZARD_STALL_CTRL_DEFS
`define REG_OP_BUS        2:0
`define REG_ADDR_BUS      2:0
`define WB_DATA_OP_BUS    1:0
`define REG_OP_NOP        3'd0
`define REG_OP_REG        3'd1
`define REG_OP_IH         3'd2
`define REG_OP_SP         3'd3
`define REG_OP_T          3'd4
`define WB_DATA_OP_NONE   2'd0
`define WB_DATA_OP_ALU    2'd1
`define WB_DATA_OP_MEM    2'd2
`endif

module tb_hazard_stall_ctrl;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 4;
    localparam int          CntMax = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();
`else
    hazard_stall_ctrl_if bus ();
`endif

    hazard_stall_ctrl #(
        .MEM_TIMEOUT(T),
        .CNT_W      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic                   rst;
        logic [`REG_OP_BUS]     o1, o2, io;
        logic [`REG_ADDR_BUS]   a1, a2, wa;
        logic [`WB_DATA_OP_BUS] wdo;
        logic                   br, req, rdy;
    } stim_t;

    typedef struct {
        int pc, ifid, flush, idex_stall, idex_bubble, exmem, memwb, timeout;
        int lu_cnt, mem_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: stall cycles already spent on the current RAM access.
    int   stalls    = 0;
    bit   timed_out = 1'b0;
    int   lu_cnt    = 0;
    int   mem_cnt   = 0;

    function automatic bit reads(input logic [2:0] op, input logic [2:0] addr,
                                 input logic [2:0] dop, input logic [2:0] daddr);
        if (op == `REG_OP_NOP || op != dop) return 1'b0;
        return (op != `REG_OP_REG) || (addr == daddr);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Drive one cycle of stimulus, push the expected response, advance the model.
    task automatic apply(input stim_t s);
        exp_t e;
        bit   lu, ab, mh;
        @(posedge clk);
        #1;
        rst                 = s.rst;
        bus.id_reg1_op      = s.o1;
        bus.id_reg2_op      = s.o2;
        bus.id_reg1_addr    = s.a1;
        bus.id_reg2_addr    = s.a2;
        bus.ide_reg_op      = s.io;
        bus.ide_wb_addr     = s.wa;
        bus.ide_wb_data_op  = s.wdo;
        bus.id_branch_taken = s.br;
        bus.exm_ram_req     = s.req;
        bus.ram_ready       = s.rdy;

        lu = (s.wdo == `WB_DATA_OP_MEM) &&
             (reads(s.o1, s.a1, s.io, s.wa) || reads(s.o2, s.a2, s.io, s.wa));
        // Budget of T stall cycles spent and still not ready: the access is dropped.
        ab = (stalls == int'(T)) && !s.rdy;
        mh = s.req && !s.rdy && !ab;

        e = '{default: 0};
        e.timeout = int'(timed_out);
        e.lu_cnt  = lu_cnt;
        e.mem_cnt = mem_cnt;
        if (mh) begin
            e.pc = 1; e.ifid = 1; e.idex_stall = 1; e.exmem = 1; e.memwb = 1;
        end else if (!ab) begin
            if (lu) begin
                e.pc = 1; e.ifid = 1; e.idex_bubble = 1;
            end else begin
                e.flush = int'(s.br);
            end
        end
        exp_q.push_back(e);

        if (s.rst) begin
            stalls = 0; timed_out = 1'b0; lu_cnt = 0; mem_cnt = 0;
        end else begin
            if (ab) begin
                timed_out = 1'b1;
                stalls    = 0;
            end else if (mh) begin
                stalls++;
            end else begin
                stalls = 0;
            end
            if (e.idex_bubble == 1 && lu_cnt < CntMax) lu_cnt++;
            if (e.exmem == 1 && mem_cnt < CntMax) mem_cnt++;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp, input int cyc);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare against the oldest expectation.
    initial begin
        exp_t e;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                chk("pc_stall",      int'(bus.pc_stall),      e.pc,          cyc);
                chk("ifid_stall",    int'(bus.ifid_stall),    e.ifid,        cyc);
                chk("ifid_flush",    int'(bus.ifid_flush),    e.flush,       cyc);
                chk("idex_stall",    int'(bus.idex_stall),    e.idex_stall,  cyc);
                chk("idex_bubble",   int'(bus.idex_bubble),   e.idex_bubble, cyc);
                chk("exmem_stall",   int'(bus.exmem_stall),   e.exmem,       cyc);
                chk("memwb_bubble",  int'(bus.memwb_bubble),  e.memwb,       cyc);
                chk("stall_timeout", int'(bus.stall_timeout), e.timeout,     cyc);
`ifdef HAZARD_PERF_CNT_EN
                chk("lu_stall_cnt",  int'(bus.lu_stall_cnt),  e.lu_cnt,      cyc);
                chk("mem_stall_cnt", int'(bus.mem_stall_cnt), e.mem_cnt,     cyc);
`endif
            end
        end
    end

    initial begin
        stim_t s;
        int    waited;

        // Reset is applied from time zero so the first sampled cycle already sees clean state.
        rst                 = 1'b1;
        bus.id_reg1_op      = `REG_OP_NOP;
        bus.id_reg2_op      = `REG_OP_NOP;
        bus.id_reg1_addr    = '0;
        bus.id_reg2_addr    = '0;
        bus.ide_reg_op      = `REG_OP_NOP;
        bus.ide_wb_addr     = '0;
        bus.ide_wb_data_op  = `WB_DATA_OP_NONE;
        bus.id_branch_taken = 1'b0;
        bus.exm_ram_req     = 1'b0;
        bus.ram_ready       = 1'b0;

        // Reset with idle inputs: everything low.
        s = idle(); s.rst = 1'b1;
        apply(s); apply(s);
        s.rst = 1'b0;
        apply(s);

        // Load-use on a general register, then the load moves on; different index: no stall.
        s = idle();
        s.wdo = `WB_DATA_OP_MEM; s.io = `REG_OP_REG; s.wa = 3'd3;
        s.o1 = `REG_OP_REG; s.a1 = 3'd3;
        apply(s);
        s.wdo = `WB_DATA_OP_ALU; s.io = `REG_OP_NOP;
        apply(s);
        s.wdo = `WB_DATA_OP_MEM; s.io = `REG_OP_REG; s.a1 = 3'd4;
        apply(s);

        // Special registers ignore the address; different special register: no bubble.
        s = idle();
        s.wdo = `WB_DATA_OP_MEM; s.io = `REG_OP_SP; s.wa = 3'd1;
        s.o2 = `REG_OP_SP; s.a2 = 3'($urandom_range(0, 7));
        apply(s);
        s.o2 = `REG_OP_IH;
        apply(s);

        // Taken branch during a load-use bubble is held back, flushes the following cycle.
        s.o2 = `REG_OP_SP; s.br = 1'b1;
        apply(s);
        s.io = `REG_OP_NOP; s.wdo = `WB_DATA_OP_ALU;
        apply(s);

        // RAM wait: ready on the 4th cycle gives 3 hold cycles.
        s = idle(); s.req = 1'b1;
        apply(s); apply(s); apply(s);
        s.rdy = 1'b1;
        apply(s);
        s = idle();
        apply(s);

        // Ready in the request cycle costs nothing; load-use then shows through.
        s.req = 1'b1; s.rdy = 1'b1;
        s.wdo = `WB_DATA_OP_MEM; s.io = `REG_OP_REG; s.wa = 3'd2;
        s.o1 = `REG_OP_REG; s.a1 = 3'd2;
        apply(s);
        // Hold and load-use together: hold wins, then load-use after release.
        s.rdy = 1'b0;
        apply(s);
        s.rdy = 1'b1;
        apply(s);
        s = idle();
        apply(s);

        // Timeout: T hold cycles, then the abort cycle, then sticky flag.
        s = idle(); s.req = 1'b1; s.br = 1'b1;
        repeat (T + 1) apply(s);
        s = idle();
        apply(s); apply(s);

        // Reset mid-wait: flag and counters clear, and the timeout budget restarts.
        s = idle(); s.req = 1'b1;
        apply(s); apply(s);
        s.rst = 1'b1;
        apply(s);
        s.rst = 1'b0;
        repeat (T + 2) apply(s);
        s = idle();
        apply(s);

        // Random traffic; a pending RAM access keeps its request asserted.
        for (int i = 0; i < 1500; i++) begin
            s.rst = ($urandom_range(0, 199) == 0);
            s.o1  = 3'($urandom_range(0, 4));
            s.o2  = 3'($urandom_range(0, 4));
            s.io  = 3'($urandom_range(0, 4));
            s.a1  = 3'($urandom_range(0, 3));
            s.a2  = 3'($urandom_range(0, 3));
            s.wa  = 3'($urandom_range(0, 3));
            s.wdo = 2'($urandom_range(0, 2));
            s.br  = 1'($urandom_range(0, 1));
            s.req = (stalls > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            s.rdy = ($urandom_range(0, 3) == 0);
            apply(s);
        end
        s = idle();
        apply(s);

        // Let the monitor drain the scoreboard, within a bounded number of cycles.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
